bmem_burst_arbiter: RTL and testbench

- Clocked, burst-aware arbiter that shares the single 64-bit burst memory port between the instruction and data cacheline adapters.
- Grants one requester at a time and latches its command. The grant is held until the full BURST_LEN-beat transaction completes, so beats from the two caches never interleave.
- Round-robin fairness. On the final beat the grant can be handed directly to the other requester.
- Sits between the two cacheline adapters and the bmem interface at the top of the memory hierarchy.

---
 rtl/bmem_burst_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_bmem_burst_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bmem_burst_arbiter
//  Purpose  : Shares the single 64-bit burst memory port between the
//             instruction-side and data-side cacheline adapters. One side is
//             granted at a time and keeps the grant for a full BURST_LEN-beat
//             transaction. Ties are resolved round-robin, and on the final
//             beat the grant can pass directly to a waiting other side.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             i_bmem_* (in/out)     - I-side request and response channel
//             d_bmem_* (in/out)     - D-side request and response channel
//             bmem_*   (out/in)     - shared burst memory port
//             busy                  - high while any side holds the grant
//  Revision : 1.0  initial release
// ============================================================================
module bmem_burst_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = $clog2(BURST_LEN)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_bmem_address,
    input  logic        i_bmem_read,
    input  logic        i_bmem_write,
    input  logic [63:0] i_bmem_wdata,
    output logic [63:0] i_bmem_rdata,
    output logic        i_bmem_resp,
    input  logic [31:0] d_bmem_address,
    input  logic        d_bmem_read,
    input  logic        d_bmem_write,
    input  logic [63:0] d_bmem_wdata,
    output logic [63:0] d_bmem_rdata,
    output logic        d_bmem_resp,
    output logic [31:0] bmem_address,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_resp,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_d_q, last_d_d;    // 1: D was granted most recently
    logic [31:0]        addr_q, addr_d;
    logic               read_q, read_d;
    logic               write_q, write_d;

    logic               req_i, req_d;
    logic               final_beat;
    logic               grant_i, grant_d;

    assign req_i      = i_bmem_read | i_bmem_write;
    assign req_d      = d_bmem_read | d_bmem_write;
    assign final_beat = bmem_resp && (cnt_q == CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        read_d   = read_q;
        write_d  = write_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A tie goes to whichever side was not granted last.
                if (req_i && (!req_d || last_d_q)) begin
                    grant_i = 1'b1;
                end else if (req_d) begin
                    grant_d = 1'b1;
                end
            end
            I_BUSY: begin
                // The finishing side's request is still high on its final
                // beat, so only the other side is considered for handoff.
                if (final_beat) begin
                    if (req_d) begin
                        grant_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                    end
                end else if (bmem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            D_BUSY: begin
                if (final_beat) begin
                    if (req_i) begin
                        grant_i = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                    end
                end else if (bmem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase

        // Command latch on grant; read wins if a requester raises both.
        if (grant_i) begin
            state_d  = I_BUSY;
            cnt_d    = '0;
            last_d_d = 1'b0;
            addr_d   = i_bmem_address;
            read_d   = i_bmem_read;
            write_d  = i_bmem_write & ~i_bmem_read;
        end else if (grant_d) begin
            state_d  = D_BUSY;
            cnt_d    = '0;
            last_d_d = 1'b1;
            addr_d   = d_bmem_address;
            read_d   = d_bmem_read;
            write_d  = d_bmem_write & ~d_bmem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b1;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            write_q  <= write_d;
        end
    end

    assign bmem_address = addr_q;
    assign bmem_read    = read_q;
    assign bmem_write   = write_q;
    assign busy         = (state_q != IDLE);

    // Data steering: only the granted side sees beats; memory responses
    // arriving in IDLE go nowhere.
    always_comb begin
        bmem_wdata   = '0;
        i_bmem_rdata = '0;
        i_bmem_resp  = 1'b0;
        d_bmem_rdata = '0;
        d_bmem_resp  = 1'b0;
        case (state_q)
            I_BUSY: begin
                bmem_wdata   = i_bmem_wdata;
                i_bmem_rdata = bmem_rdata;
                i_bmem_resp  = bmem_resp;
            end
            D_BUSY: begin
                bmem_wdata   = d_bmem_wdata;
                d_bmem_rdata = bmem_rdata;
                d_bmem_resp  = bmem_resp;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bmem_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bmem_burst_arbiter
//  Purpose  : Directed self-checking bench for bmem_burst_arbiter. Beats are
//             recorded in a scoreboard queue as they are driven and checked
//             against the per-side response outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bmem_burst_arbiter;

    localparam logic [63:0] I_WDATA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_WDATA = 64'hAAAA_BBBB_CCCC_DDDD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_bmem_address, d_bmem_address;
    logic        i_bmem_read, i_bmem_write, d_bmem_read, d_bmem_write;
    logic [63:0] i_bmem_wdata, d_bmem_wdata;
    logic [63:0] i_bmem_rdata, d_bmem_rdata;
    logic        i_bmem_resp, d_bmem_resp;
    logic [31:0] bmem_address;
    logic        bmem_read, bmem_write;
    logic [63:0] bmem_wdata, bmem_rdata;
    logic        bmem_resp;
    logic        busy;

    typedef struct packed {
        logic        side;   // 0: I, 1: D
        logic [63:0] data;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    bmem_burst_arbiter #(.BURST_LEN(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_bmem_address (i_bmem_address),
        .i_bmem_read    (i_bmem_read),
        .i_bmem_write   (i_bmem_write),
        .i_bmem_wdata   (i_bmem_wdata),
        .i_bmem_rdata   (i_bmem_rdata),
        .i_bmem_resp    (i_bmem_resp),
        .d_bmem_address (d_bmem_address),
        .d_bmem_read    (d_bmem_read),
        .d_bmem_write   (d_bmem_write),
        .d_bmem_wdata   (d_bmem_wdata),
        .d_bmem_rdata   (d_bmem_rdata),
        .d_bmem_resp    (d_bmem_resp),
        .bmem_address   (bmem_address),
        .bmem_read      (bmem_read),
        .bmem_write     (bmem_write),
        .bmem_wdata     (bmem_wdata),
        .bmem_rdata     (bmem_rdata),
        .bmem_resp      (bmem_resp),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every beat driven this cycle was pushed before this sample point; with
    // nothing pushed, neither side may see a response strobe.
    always @(negedge clk) begin
        #2;
        if (sb.size() != 0) begin
            beat_t b;
            b = sb.pop_front();
            chk("resp_i",  64'(i_bmem_resp), 64'(b.side == 1'b0));
            chk("resp_d",  64'(d_bmem_resp), 64'(b.side == 1'b1));
            chk("rdata",   b.side ? d_bmem_rdata : i_bmem_rdata, b.data);
            chk("rdata_x", b.side ? i_bmem_rdata : d_bmem_rdata, 64'h0);
        end else begin
            chk("no_resp", 64'({i_bmem_resp, d_bmem_resp}), 64'h0);
        end
    end

    task automatic clear_reqs();
        i_bmem_read  = 1'b0;
        i_bmem_write = 1'b0;
        d_bmem_read  = 1'b0;
        d_bmem_write = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [31:0] addr,
                                input logic rd, input logic wr, input logic [63:0] wdata);
        @(negedge clk);
        bmem_resp = 1'b0;
        #2;
        chk({tag, "_busy"},  64'(busy), 64'h1);
        chk({tag, "_addr"},  64'(bmem_address), 64'(addr));
        chk({tag, "_read"},  64'(bmem_read), 64'(rd));
        chk({tag, "_write"}, 64'(bmem_write), 64'(wr));
        chk({tag, "_wdata"}, bmem_wdata, wdata);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        bmem_resp = 1'b0;
        clear_reqs();
        #2;
        chk({tag, "_busy"},  64'(busy), 64'h0);
        chk({tag, "_rw"},    64'({bmem_read, bmem_write}), 64'h0);
        chk({tag, "_wdata"}, bmem_wdata, 64'h0);
    endtask

    task automatic burst(input logic side, input logic [63:0] seed, input int n,
                         input logic [31:0] exp_addr, input logic drop_last,
                         input logic mutate);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            @(negedge clk);
            bmem_resp  = 1'b1;
            bmem_rdata = seed * 64'(k + 1);
            if (mutate && k == 1) i_bmem_address = 32'hDEAD_BEE0;
            if (drop_last && k == n - 1) clear_reqs();
            b.side = side;
            b.data = bmem_rdata;
            sb.push_back(b);
            #2;
            chk("burst_addr", 64'(bmem_address), 64'(exp_addr));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        i_bmem_address = '0;
        d_bmem_address = '0;
        i_bmem_wdata   = I_WDATA;
        d_bmem_wdata   = D_WDATA;
        bmem_rdata     = '0;
        bmem_resp      = 1'b0;
        clear_reqs();
        #2;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rw",   64'({bmem_read, bmem_write}), 64'h0);
        chk("rst_addr", 64'(bmem_address), 64'h0);
        chk("rst_out",  bmem_wdata | i_bmem_rdata | d_bmem_rdata, 64'h0);

        // 1: lone I read
        @(negedge clk);
        rst_n          = 1'b1;
        i_bmem_read    = 1'b1;
        i_bmem_address = 32'h0000_1000;
        #2;
        chk("t1_latency", 64'(busy), 64'h0);
        expect_grant("t1", 32'h0000_1000, 1'b1, 1'b0, I_WDATA);
        burst(1'b0, 64'h11, 4, 32'h0000_1000, 1'b0, 1'b0);
        expect_idle("t1_end");

        // 2: simultaneous I read and D write after reset -> I then D, no gap
        pulse_reset();
        @(negedge clk);
        i_bmem_read    = 1'b1;
        i_bmem_address = 32'h0000_2000;
        d_bmem_write   = 1'b1;
        d_bmem_address = 32'h0000_3000;
        expect_grant("t2_i", 32'h0000_2000, 1'b1, 1'b0, I_WDATA);
        burst(1'b0, 64'h21, 4, 32'h0000_2000, 1'b0, 1'b0);
        expect_grant("t2_d", 32'h0000_3000, 1'b0, 1'b1, D_WDATA);
        burst(1'b1, 64'h0, 4, 32'h0000_3000, 1'b1, 1'b0);
        expect_idle("t2_end");

        // 3: both request continuously -> I, D, I, D
        @(negedge clk);
        i_bmem_read    = 1'b1;
        i_bmem_address = 32'h0000_5000;
        d_bmem_read    = 1'b1;
        d_bmem_address = 32'h0000_5100;
        for (int t = 0; t < 4; t++) begin
            logic        sd;
            logic [31:0] a;
            sd = t[0];
            a  = sd ? 32'h0000_5100 : 32'h0000_5000;
            expect_grant("t3", a, 1'b1, 1'b0, sd ? D_WDATA : I_WDATA);
            burst(sd, 64'h100 + 64'(t), 4, a, t == 3, 1'b0);
        end
        expect_idle("t3_end");

        // 4: I address change mid-burst is ignored
        @(negedge clk);
        i_bmem_read    = 1'b1;
        i_bmem_address = 32'h0000_4000;
        expect_grant("t4", 32'h0000_4000, 1'b1, 1'b0, I_WDATA);
        burst(1'b0, 64'h31, 4, 32'h0000_4000, 1'b0, 1'b1);
        expect_idle("t4_end");

        // 5: spurious resp in IDLE
        @(negedge clk);
        bmem_resp  = 1'b1;
        bmem_rdata = 64'h55;
        #2;
        chk("t5_busy",  64'(busy), 64'h0);
        chk("t5_rdata", i_bmem_rdata | d_bmem_rdata, 64'h0);
        expect_idle("t5_end");

        // 6: reset during D burst, then a tie goes to I with a full burst
        @(negedge clk);
        d_bmem_read    = 1'b1;
        d_bmem_address = 32'h0000_6000;
        expect_grant("t6_d", 32'h0000_6000, 1'b1, 1'b0, D_WDATA);
        burst(1'b1, 64'h41, 2, 32'h0000_6000, 1'b0, 1'b0);
        @(negedge clk);
        bmem_resp = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_rw",   64'({bmem_read, bmem_write}), 64'h0);
        chk("t6_rst_addr", 64'(bmem_address), 64'h0);
        clear_reqs();
        @(negedge clk);
        rst_n          = 1'b1;
        i_bmem_read    = 1'b1;
        i_bmem_address = 32'h0000_7000;
        d_bmem_read    = 1'b1;
        d_bmem_address = 32'h0000_8000;
        expect_grant("t6_i", 32'h0000_7000, 1'b1, 1'b0, I_WDATA);
        burst(1'b0, 64'h51, 4, 32'h0000_7000, 1'b0, 1'b0);
        expect_grant("t6_d2", 32'h0000_8000, 1'b1, 1'b0, D_WDATA);
        burst(1'b1, 64'h61, 4, 32'h0000_8000, 1'b1, 1'b0);
        expect_idle("t6_end");

        @(negedge clk);
        #3;
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
